mul_man_sched: RTL and testbench

- Shares one combinational 11x11 mantissa carry-save compressor (mul_man_comp) between two MAC-lane requesters.
- Arbitrates round-robin and drives the compressor operands.
- Registers the carry-save pair and performs the final carry-propagate add.
- Returns each 22-bit product with its tag to the originating lane through a 2-entry per-lane output queue with valid/ready backpressure.

---
 rtl/mul_man_sched.sv | 181 ++++++++++++++++++
 tb/tb_mul_man_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_man_sched.sv
// Shares one 11x11 mantissa carry-save compressor between two MAC lanes, finishes the
// carry-propagate add and returns each product through a 2-deep per-lane result queue.
module mul_man_sched #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [10:0]      req0_op1,
  input  logic [10:0]      req0_op2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [10:0]      req1_op1,
  input  logic [10:0]      req1_op2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [10:0]      comp_op1,
  output logic [10:0]      comp_op2,
  input  logic [23:0]      comp_result_a,
  input  logic [18:0]      comp_result_b,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [21:0]      out0_prod,
  output logic [TAG_W-1:0] out0_tag,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [21:0]      out1_prod,
  output logic [TAG_W-1:0] out1_tag,
  output logic             busy
);
  logic [1:0]       req_valid;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       push;
  logic [1:0]       out_ready;
  logic [1:0]       out_valid;
  logic [10:0]      req_op1 [2];
  logic [10:0]      req_op2 [2];
  logic [TAG_W-1:0] req_tag [2];
  logic [21:0]      head_prod [2];
  logic [TAG_W-1:0] head_tag [2];
  logic [1:0]       cnt [2];
  logic [TAG_W-1:0] grant_tag;

  logic             last_reg;
  logic             s1_valid_reg;
  logic             s1_dest_reg;
  logic [23:0]      s1_a_reg;
  logic [18:0]      s1_b_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic [18:0]      hi_sum;
  logic [23:0]      sum24;
  logic [21:0]      prod;

  assign req_valid  = {req1_valid, req0_valid};
  assign out_ready  = {out1_ready, out0_ready};
  assign req_op1[0] = req0_op1;
  assign req_op1[1] = req1_op1;
  assign req_op2[0] = req0_op2;
  assign req_op2[1] = req1_op2;
  assign req_tag[0] = req0_tag;
  assign req_tag[1] = req1_tag;

  // A lane may only be granted if its queue can still hold everything already in flight.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_credit
      assign push[gi] = s1_valid_reg & (s1_dest_reg == 1'(gi));
      assign elig[gi] = rst_n & en & req_valid[gi] &
                        (({1'b0, cnt[gi]} + {2'b00, push[gi]}) < 3'd2);
    end
  endgenerate

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_reg ? 2'b01 : 2'b10;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    comp_op1  = '0;
    comp_op2  = '0;
    grant_tag = '0;
    if (grant[0]) begin
      comp_op1  = req_op1[0];
      comp_op2  = req_op2[0];
      grant_tag = req_tag[0];
    end else if (grant[1]) begin
      comp_op1  = req_op1[1];
      comp_op2  = req_op2[1];
      grant_tag = req_tag[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg     <= 1'b1;
      s1_valid_reg <= 1'b0;
      s1_dest_reg  <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_tag_reg   <= '0;
    end else begin
      s1_valid_reg <= |grant;
      if (|grant) begin
        last_reg    <= grant[1];
        s1_dest_reg <= grant[1];
        s1_a_reg    <= comp_result_a;
        s1_b_reg    <= comp_result_b;
        s1_tag_reg  <= grant_tag;
      end
    end
  end

  // Carry vector is aligned at bit 5, so only the upper 19 bits need the adder.
  assign hi_sum = s1_a_reg[23:5] + s1_b_reg;
  assign sum24  = {hi_sum, s1_a_reg[4:0]};
  assign prod   = sum24[21:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_queue
      logic [21:0]      prod_mem [2];
      logic [TAG_W-1:0] tag_mem [2];
      logic             wr_ptr_reg;
      logic             rd_ptr_reg;
      logic [1:0]       cnt_reg;
      logic             pop;

      assign pop = out_valid[gi] & out_ready[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_mem[0] <= '0;
          prod_mem[1] <= '0;
          tag_mem[0]  <= '0;
          tag_mem[1]  <= '0;
          wr_ptr_reg  <= 1'b0;
          rd_ptr_reg  <= 1'b0;
          cnt_reg     <= 2'd0;
        end else begin
          if (push[gi]) begin
            prod_mem[wr_ptr_reg] <= prod;
            tag_mem[wr_ptr_reg]  <= s1_tag_reg;
            wr_ptr_reg           <= ~wr_ptr_reg;
          end
          if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
          end
          cnt_reg <= cnt_reg + {1'b0, push[gi]} - {1'b0, pop};
        end
      end

      assign cnt[gi]       = cnt_reg;
      assign out_valid[gi] = (cnt_reg != 2'd0);
      assign head_prod[gi] = prod_mem[rd_ptr_reg];
      assign head_tag[gi]  = tag_mem[rd_ptr_reg];

      a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push[gi] && cnt_reg == 2'd2));
    end
  endgenerate

  a_prod_fits: assert property (@(posedge clk) disable iff (!rst_n)
    !s1_valid_reg || sum24[23:22] == 2'b00);

  assign out0_valid = out_valid[0];
  assign out0_prod  = head_prod[0];
  assign out0_tag   = head_tag[0];
  assign out1_valid = out_valid[1];
  assign out1_prod  = head_prod[1];
  assign out1_tag   = head_tag[1];

  assign busy = s1_valid_reg | (cnt[0] != 2'd0) | (cnt[1] != 2'd0);

endmodule

// File: tb/tb_mul_man_sched.sv
// Self-checking bench for mul_man_sched: directed vectors, arbitration/backpressure
// sequences and a randomized run checked against a per-lane expected-result scoreboard.
module tb_mul_man_sched;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [10:0]      req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [10:0]      comp_op1, comp_op2;
  logic [23:0]      comp_result_a;
  logic [18:0]      comp_result_b;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b0, out1_ready = 1'b0;
  logic [21:0]      out0_prod, out1_prod;
  logic [TAG_W-1:0] out0_tag, out1_tag;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_man_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_tag(req1_tag),
    .comp_op1(comp_op1), .comp_op2(comp_op2),
    .comp_result_a(comp_result_a), .comp_result_b(comp_result_b),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_prod(out0_prod), .out0_tag(out0_tag),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_prod(out1_prod), .out1_tag(out1_tag),
    .busy(busy)
  );

  // Compressor stand-in: a random but consistent carry-save split of the true product.
  logic [18:0] split_b = '0;
  logic [23:0] full_p;
  always_comb begin
    full_p        = 24'(comp_op1) * 24'(comp_op2);
    comp_result_b = split_b;
    comp_result_a = {full_p[23:5] - split_b, full_p[4:0]};
  end
  always @(negedge clk) split_b <= 19'($urandom);

  typedef struct packed {
    logic [21:0]      prod;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t exp_q0[$];
  res_t exp_q1[$];
  res_t e0, e1, rq;

  function automatic logic [21:0] ref_mul(input logic [10:0] a, input logic [10:0] b);
    logic [21:0] p;
    p = 22'(a) * 22'(b);
    return p;
  endfunction

  function automatic logic [10:0] rand_op();
    int unsigned r = $urandom_range(0, 7);
    if (r == 0) return 11'h7FF;
    if (r == 1) return 11'h000;
    return 11'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted request must come back on its own lane, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (exp_q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb0_unexpected: got prod=0x%0h tag=%0d, required no result", out0_prod, out0_tag);
        end else begin
          e0 = exp_q0.pop_front();
          chk("sb0_prod", 32'(out0_prod), 32'(e0.prod));
          chk("sb0_tag", 32'(out0_tag), 32'(e0.tag));
        end
      end
      if (out1_valid && out1_ready) begin
        if (exp_q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb1_unexpected: got prod=0x%0h tag=%0d, required no result", out1_prod, out1_tag);
        end else begin
          e1 = exp_q1.pop_front();
          chk("sb1_prod", 32'(out1_prod), 32'(e1.prod));
          chk("sb1_tag", 32'(out1_tag), 32'(e1.tag));
        end
      end
      if (req0_valid && req0_ready) begin
        rq.prod = ref_mul(req0_op1, req0_op2);
        rq.tag  = req0_tag;
        exp_q0.push_back(rq);
      end
      if (req1_valid && req1_ready) begin
        rq.prod = ref_mul(req1_op1, req1_op2);
        rq.tag  = req1_tag;
        exp_q1.push_back(rq);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One free-running cycle: note the handshakes due at the coming edge, then refresh operands.
  task automatic run_cycle(output bit acc0, output bit acc1);
    @(negedge clk);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    step();
    if (acc0) req0_tag++;
    if (acc1) req1_tag++;
    req0_op1 = rand_op();
    req0_op2 = rand_op();
    req1_op1 = rand_op();
    req1_op2 = rand_op();
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int k = 0; k < 40 && busy; k++) step();
    chk("drain_busy", 32'(busy), 0);
    chk("drain_sb_empty", 32'(exp_q0.size() + exp_q1.size()), 0);
  endtask

  typedef struct {
    bit               lane;
    logic [10:0]      op1;
    logic [10:0]      op2;
    logic [TAG_W-1:0] tag;
    logic [21:0]      prod;
  } vec_t;

  vec_t             tbl [7];
  logic             rdy, ov;
  logic [21:0]      op;
  logic [TAG_W-1:0] ot;
  bit               a0, a1;
  int               n0, n1, total, cyc;

  initial begin
    tbl[0] = '{1'b0, 11'h400, 11'h400, 4'd3,  22'h100000};
    tbl[1] = '{1'b1, 11'h7FF, 11'h7FF, 4'd5,  22'h3FF001};
    tbl[2] = '{1'b0, 11'h000, 11'h7FF, 4'd7,  22'h000000};
    tbl[3] = '{1'b1, 11'h400, 11'h7FF, 4'd9,  22'h1FFC00};
    tbl[4] = '{1'b0, 11'h7FF, 11'h001, 4'd10, 22'h0007FF};
    tbl[5] = '{1'b1, 11'h555, 11'h2AA, 4'd12, 22'h0E3472};
    tbl[6] = '{1'b0, 11'h123, 11'h010, 4'd15, 22'h001230};

    // Reset state, with requests pending so ready gating is visible.
    en = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #12;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Tie: grants alternate starting with lane 0, each lane delivering every 2 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("tie_grant0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("tie_grant1", 32'(req1_ready), 32'(k % 2 == 1));
      chk("tie_out0", 32'(out0_valid), 32'(k >= 2 && k % 2 == 0));
      chk("tie_out1", 32'(out1_valid), 32'(k >= 3 && k % 2 == 1));
      step();
      req0_op1 = rand_op(); req0_op2 = rand_op(); req0_tag++;
      req1_op1 = rand_op(); req1_op2 = rand_op(); req1_tag++;
    end
    $display("[TB] tie sequence: 10 cycles of alternating grants");
    drain();

    // Directed single requests: same-cycle ready, 2-cycle latency, one-cycle result.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].lane) begin
        req1_valid = 1'b1; req1_op1 = tbl[i].op1; req1_op2 = tbl[i].op2; req1_tag = tbl[i].tag;
      end else begin
        req0_valid = 1'b1; req0_op1 = tbl[i].op1; req0_op2 = tbl[i].op2; req0_tag = tbl[i].tag;
      end
      @(negedge clk);
      rdy = tbl[i].lane ? req1_ready : req0_ready;
      chk("tbl_ready", 32'(rdy), 1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      ov = tbl[i].lane ? out1_valid : out0_valid;
      chk("tbl_not_early", 32'(ov), 0);
      @(negedge clk);
      ov = tbl[i].lane ? out1_valid : out0_valid;
      op = tbl[i].lane ? out1_prod : out0_prod;
      ot = tbl[i].lane ? out1_tag : out0_tag;
      chk("tbl_valid", 32'(ov), 1);
      chk("tbl_prod", 32'(op), 32'(tbl[i].prod));
      chk("tbl_tag", 32'(ot), 32'(tbl[i].tag));
      @(negedge clk);
      ov = tbl[i].lane ? out1_valid : out0_valid;
      chk("tbl_one_cycle", 32'(ov), 0);
      step();
      $display("[TB] vec %0d lane %0d 0x%03h*0x%03h -> 0x%06h tag %0d",
               i, tbl[i].lane, tbl[i].op1, tbl[i].op2, op, ot);
    end

    // Backpressure on lane 0 must cap it at two accepts without stalling lane 1.
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 16; k++) begin
      run_cycle(a0, a1);
      if (a0) n0++;
      if (k >= 8) begin
        chk("bp_req0_blocked", 32'(a0), 0);
        if (a1) n1++;
      end
    end
    chk("bp_lane0_accepts", 32'(n0), 2);
    chk("bp_lane1_flow", 32'(n1 >= 5), 1);
    out0_ready = 1'b1;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(a0, a1);
      if (a0) n0++;
    end
    chk("bp_lane0_resume", 32'(n0 > 0), 1);
    $display("[TB] backpressure sequence: lane 1 accepts in window %0d", n1);
    drain();

    // en drop with S1 occupied and one result waiting in each queue.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle(a0, a1);
    en = 1'b0;
    @(negedge clk);
    chk("en_req0_ready", 32'(req0_ready), 0);
    chk("en_req1_ready", 32'(req1_ready), 0);
    chk("en_out0_held", 32'(out0_valid), 1);
    chk("en_out1_held", 32'(out1_valid), 1);
    chk("en_busy_high", 32'(busy), 1);
    step();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("en_no_grant", 32'(req0_ready | req1_ready), 0);
      step();
    end
    chk("en_busy_low", 32'(busy), 0);
    chk("en_delivered", 32'(exp_q0.size() + exp_q1.size()), 0);
    $display("[TB] en-drop sequence drained");
    en = 1'b1;
    drain();

    // Reset mid-stream: everything in flight vanishes, arbitration restarts at lane 0.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) run_cycle(a0, a1);
    rst_n = 1'b0;
    #1;
    chk("rstm_out0_valid", 32'(out0_valid), 0);
    chk("rstm_out1_valid", 32'(out1_valid), 0);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_req_ready", 32'(req0_ready | req1_ready), 0);
    exp_q0.delete();
    exp_q1.delete();
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("rstm_first_grant0", 32'(req0_ready), 1);
    chk("rstm_first_grant1", 32'(req1_ready), 0);
    step();
    for (int k = 0; k < 8; k++) run_cycle(a0, a1);
    $display("[TB] mid-stream reset sequence done");
    drain();

    // Randomized traffic until 1000 products have been accepted.
    total = 0;
    cyc = 0;
    while (total < 1000 && cyc < 20000) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      en         = ($urandom_range(0, 7) != 0);
      run_cycle(a0, a1);
      total += int'(a0) + int'(a1);
      cyc++;
    end
    chk("rand_accept_count", 32'(total >= 1000), 1);
    en = 1'b1;
    $display("[TB] random run: %0d accepts in %0d cycles", total, cyc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
